// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S master that queues stereo sample pairs in a FIFO and serializes them MSB-first.
module i2s_transmitter #(
  parameter int SAMPLE_W   = 18,
  parameter int BCLK_HALF  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [SAMPLE_W-1:0]                   s_left,
  input  logic [SAMPLE_W-1:0]                   s_right,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic                                  BCLK,
  output logic                                  LRCLK,
  output logic                                  SDATA,
  output logic                                  underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = $clog2(BCLK_HALF + 1);
  logic [DW-1:0]         div_cnt;
  logic [5:0]            b, nb;
  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [2*SAMPLE_W-1:0] frame;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [SAMPLE_W-1:0]   word;
  logic [31:0]           slot_word;
  logic                  wrap, fall, load, push, pop, sbit;
  // slot_word places the sample one bit below the slot MSB, giving the I2S one-bit delay
  always_comb begin
    wrap      = div_cnt == DW'(BCLK_HALF - 1);
    fall      = wrap & BCLK;
    nb        = b + 6'd1;
    load      = fall & (b == 6'd63);
    s_ready   = reset & (fifo_level != LW'(FIFO_DEPTH));
    push      = s_valid & s_ready;
    pop       = load & (fifo_level != '0);
    word      = nb[5] ? frame[SAMPLE_W-1:0] : frame[2*SAMPLE_W-1:SAMPLE_W];
    slot_word = 32'(word) << (31 - SAMPLE_W);
    sbit      = slot_word[~nb[4:0]];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt    <= '0;
      BCLK       <= 1'b0;
      LRCLK      <= 1'b0;
      SDATA      <= 1'b0;
      underrun   <= 1'b0;
      b          <= '0;
      frame      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      div_cnt  <= wrap ? '0 : div_cnt + DW'(1);
      BCLK     <= wrap ? ~BCLK : BCLK;
      b        <= fall ? nb : b;
      LRCLK    <= fall ? nb[5] : LRCLK;
      SDATA    <= fall ? sbit : SDATA;
      frame    <= load ? (pop ? mem[rd_ptr] : '0) : frame;
      underrun <= load & ~pop;
      wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_left, s_right};
  end
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: checks the I2S transmitter against a cycle-count reference model and frame captures.
module tb_i2s_transmitter;
  localparam int SW = 18;
  localparam int BH = 2;
  localparam int D  = 4;
  localparam int FR = 2 * BH * 64;
  logic clk = 0, reset = 0, s_valid = 0;
  logic [SW-1:0] s_left = '0, s_right = '0;
  logic s_ready, BCLK, LRCLK, SDATA, underrun;
  logic [2:0] fifo_level;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  i2s_transmitter #(.SAMPLE_W(SW), .BCLK_HALF(BH), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
    .s_ready(s_ready), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA), .underrun(underrun),
    .fifo_level(fifo_level)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: everything follows from k, the number of clk edges since reset release
  int k = 0;
  logic [2*SW-1:0] q [$];
  logic [2*SW-1:0] fr = '0;
  logic m_under = 0;
  function automatic logic exp_sd(input int b, input logic [2*SW-1:0] f);
    if (b >= 1 && b <= SW) return f[2*SW-b];
    if (b >= 33 && b <= 32 + SW) return f[SW-(b-32)];
    return 1'b0;
  endfunction
  logic [63:0] sh = '0, last_frame = '0;
  int cnt = 0, frames = 0;
  logic bprev = 0;
  always @(posedge clk) begin
    int b;
    bit ready_old;
    if (!reset) begin
      k = 0;
      q.delete();
      fr = '0;
      m_under = 0;
    end else begin
      ready_old = q.size() < D;
      k++;
      m_under = 0;
      if (k % FR == 0) begin
        if (q.size() > 0) fr = q.pop_front();
        else begin
          fr = '0;
          m_under = 1;
        end
      end
      if (s_valid && ready_old) q.push_back({s_left, s_right});
    end
    #1;
    b = (k / (2 * BH)) % 64;
    chk("BCLK", BCLK, 64'((k / BH) % 2));
    chk("LRCLK", LRCLK, 64'(b >= 32));
    chk("SDATA", SDATA, 64'(exp_sd(b, fr)));
    chk("underrun", underrun, 64'(m_under));
    chk("fifo_level", fifo_level, 64'(q.size()));
    chk("s_ready", s_ready, 64'(reset && q.size() < D));
    if (!reset) begin
      cnt = 0;
      sh = '0;
    end else if (BCLK && !bprev) begin
      sh = {sh[62:0], SDATA};
      cnt++;
      if (cnt == 64) begin
        last_frame = sh;
        frames++;
        cnt = 0;
      end
    end
    bprev = BCLK;
  end
  task automatic wait_k_mod(input int r);
    int n = 0;
    while (k % FR != r && n < FR + 4) begin
      @(negedge clk);
      n++;
    end
    chk("wait_k_mod_timeout", 64'(k % FR), 64'(r));
  endtask
  task automatic wait_frames(input int nf);
    int n = 0;
    int start = frames;
    while (frames < start + nf && n < (nf + 1) * FR) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frames_timeout", 64'(frames >= start + nf), 64'(1));
  endtask
  task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int n = 0;
    s_left = l;
    s_right = r;
    s_valid = 1;
    while (!s_ready && n < 4 * FR) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", s_ready, 1);
    @(negedge clk);
    s_valid = 0;
  endtask
  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    logic [63:0]   exp;
  } vec_t;
  vec_t tbl [4];
  initial begin
    int n, idx;
    bit acc;
    tbl[0] = '{18'h2AAAA, 18'h15555, {1'b0, 18'h2AAAA, 13'b0, 1'b0, 18'h15555, 13'b0}};
    tbl[1] = '{18'h3FFFF, 18'h00000, {1'b0, 18'h3FFFF, 13'b0, 1'b0, 18'h00000, 13'b0}};
    tbl[2] = '{18'h00000, 18'h3FFFF, {1'b0, 18'h00000, 13'b0, 1'b0, 18'h3FFFF, 13'b0}};
    tbl[3] = '{18'h20000, 18'h00001, {1'b0, 18'h20000, 13'b0, 1'b0, 18'h00001, 13'b0}};
    repeat (5) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_bclk", BCLK, 0);
    reset = 1;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!BCLK && n < 10);
    chk("first_bclk_clk", 64'(n), 64'(BH));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_k_mod(8);
      push_pair(tbl[i].l, tbl[i].r);
      wait_frames(2);
      chk($sformatf("frame_vec%0d", i), last_frame, tbl[i].exp);
    end
    wait_frames(3);
    chk("silent_frame", last_frame, 64'h0);
    wait_k_mod(8);
    idx = 0;
    for (int j = 0; j < 5; j++) begin
      s_left = SW'(18'h01000 + idx);
      s_right = SW'(18'h30000 - idx);
      s_valid = 1;
      acc = s_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    chk("full_accepted", 64'(idx), 64'(4));
    chk("full_level", fifo_level, 4);
    chk("full_ready", s_ready, 0);
    push_pair(SW'(18'h01004), SW'(18'h2FFFC));
    chk("refill_level", fifo_level, 4);
    wait_frames(7);
    wait_k_mod(FR - 1);
    chk("pre_collide_level", fifo_level, 0);
    s_left = 18'h12345;
    s_right = 18'h0ABCD;
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    chk("collide_underrun", underrun, 1);
    chk("collide_level", fifo_level, 1);
    wait_frames(2);
    chk("collide_frame", last_frame, {1'b0, 18'h12345, 13'b0, 1'b0, 18'h0ABCD, 13'b0});
    wait_k_mod(8);
    push_pair(18'h11111, 18'h22222);
    push_pair(18'h33333, 18'h04444);
    push_pair(18'h05555, 18'h26666);
    n = 0;
    while ((k / (2 * BH)) % 64 != 40 && n < 2 * FR) begin
      @(negedge clk);
      n++;
    end
    chk("b40_reached", 64'((k / (2 * BH)) % 64), 64'(40));
    reset = 0;
    @(negedge clk);
    chk("mid_rst_bclk", BCLK, 0);
    chk("mid_rst_lrclk", LRCLK, 0);
    chk("mid_rst_sdata", SDATA, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", s_ready, 0);
    reset = 1;
    wait_frames(2);
    for (int c = 0; c < 20 * FR; c++) begin
      if (!(s_valid && !acc)) begin
        s_valid = ($urandom % 120) == 0;
        s_left = SW'($urandom);
        s_right = SW'($urandom);
      end
      acc = s_ready;
      @(negedge clk);
    end
    s_valid = 0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
